eespfal_lane_driver: RTL and testbench

Digital sequencer that drives one 64-bit EESPFAL switch lane and captures its result.
- Converts single-rail x/k operands into dual-rail stimulus.
- Generates the four staggered power-clock phases and the per-stage discharge enables.
- Samples the dual-rail s/s_bar result, checks rail complementarity, and returns the result through a valid/ready handshake.
- Sits between the user-project register interface and the analog lane wrapper.

---
 rtl/eespfal_lane_driver.sv | 192 +++++++++++++++++++
 tb/tb_eespfal_lane_driver.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/eespfal_lane_driver.sv
// Sequencer for one EESPFAL switch lane: dual-rail operand drive, staggered
// power-clock ramp, synchronized dual-rail capture and a valid/ready result.
module eespfal_lane_driver #(
  parameter int unsigned BIT_SIZE     = 64,
  parameter int unsigned PHASES       = 4,
  parameter int unsigned PHASE_CYCLES = 4,
  parameter int unsigned DIS_CYCLES   = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [BIT_SIZE-1:0] x_in,
  input  logic [BIT_SIZE-1:0] k_in,
  output logic [BIT_SIZE-1:0] x_top,
  output logic [BIT_SIZE-1:0] x_bar_top,
  output logic [BIT_SIZE-1:0] k_top,
  output logic [BIT_SIZE-1:0] k_bar_top,
  output logic [PHASES-1:0]   clk_top,
  output logic [PHASES-1:0]   Dis_top,
  output logic                Dis_Phase_top,
  input  logic [BIT_SIZE-1:0] s_top,
  input  logic [BIT_SIZE-1:0] s_bar_top,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [BIT_SIZE-1:0] s_out,
  output logic [BIT_SIZE-1:0] err_mask,
  output logic                err
);

  localparam int unsigned RAMP_CYCLES = PHASES * PHASE_CYCLES;
  localparam int unsigned CNT_MAX     = (RAMP_CYCLES > DIS_CYCLES) ? RAMP_CYCLES : DIS_CYCLES;
  localparam int unsigned CNT_W       = $clog2(CNT_MAX + 1);
  localparam int unsigned SETTLE_CYCLES = 2;

  typedef enum logic [2:0] {
    S_IDLE, S_DRIVE, S_EVAL, S_SETTLE, S_RELEASE, S_DISCH, S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [BIT_SIZE-1:0] x_top_d, x_bar_top_d, k_top_d, k_bar_top_d;
  logic [BIT_SIZE-1:0] s_out_d, err_mask_d;
  logic                err_d, in_ready_d, out_valid_d, dis_phase_d;
  logic [PHASES-1:0]   clk_top_d, dis_top_d;

  // Lane result is asynchronous to clk: two-flop synchronizer on both rails
  logic [BIT_SIZE-1:0] s_meta, s_sync, s_bar_meta, s_bar_sync;
  logic [BIT_SIZE-1:0] err_mask_c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_meta     <= '0;
      s_sync     <= '0;
      s_bar_meta <= '0;
      s_bar_sync <= '0;
    end else begin
      s_meta     <= s_top;
      s_sync     <= s_meta;
      s_bar_meta <= s_bar_top;
      s_bar_sync <= s_bar_meta;
    end
  end

  assign err_mask_c = ~(s_sync ^ s_bar_sync);

  // Next-state, counter and next-output logic; outputs derive from the next state
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q + CNT_W'(1);
    x_top_d     = x_top;
    x_bar_top_d = x_bar_top;
    k_top_d     = k_top;
    k_bar_top_d = k_bar_top;
    s_out_d     = s_out;
    err_mask_d  = err_mask;
    err_d       = err;
    clk_top_d   = '0;
    dis_top_d   = '0;
    dis_phase_d = 1'b0;
    in_ready_d  = 1'b0;
    out_valid_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (in_valid && in_ready) begin
          state_d     = S_DRIVE;
          x_top_d     = x_in;
          x_bar_top_d = ~x_in;
          k_top_d     = k_in;
          k_bar_top_d = ~k_in;
        end
      end
      S_DRIVE: begin
        state_d = S_EVAL;
        cnt_d   = '0;
      end
      S_EVAL: begin
        if (cnt_q == CNT_W'(RAMP_CYCLES - 1)) begin
          state_d = S_SETTLE;
          cnt_d   = '0;
        end
      end
      S_SETTLE: begin
        if (cnt_q == CNT_W'(SETTLE_CYCLES - 1)) begin
          state_d    = S_RELEASE;
          cnt_d      = '0;
          s_out_d    = s_sync;
          err_mask_d = err_mask_c;
          err_d      = |err_mask_c;
        end
      end
      S_RELEASE: begin
        if (cnt_q == CNT_W'(RAMP_CYCLES - 1)) begin
          state_d     = S_DISCH;
          cnt_d       = '0;
          x_top_d     = '0;
          x_bar_top_d = '0;
          k_top_d     = '0;
          k_bar_top_d = '0;
        end
      end
      S_DISCH: begin
        if (cnt_q == CNT_W'(DIS_CYCLES - 1)) begin
          state_d = S_DONE;
          cnt_d   = '0;
        end
      end
      S_DONE: begin
        cnt_d = '0;
        if (out_ready) state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase

    // Cumulative ramp up in EVAL, phase-0-first ramp down in RELEASE
    for (int unsigned i = 0; i < PHASES; i++) begin
      if (state_d == S_EVAL && cnt_d >= CNT_W'(i * PHASE_CYCLES))
        clk_top_d[i] = 1'b1;
      if (state_d == S_SETTLE)
        clk_top_d[i] = 1'b1;
      if (state_d == S_RELEASE && cnt_d < CNT_W'(i * PHASE_CYCLES))
        clk_top_d[i] = 1'b1;
    end

    if (state_d == S_DISCH) begin
      dis_top_d   = '1;
      dis_phase_d = 1'b1;
    end
    in_ready_d  = (state_d == S_IDLE);
    out_valid_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      in_ready      <= 1'b0;
      x_top         <= '0;
      x_bar_top     <= '0;
      k_top         <= '0;
      k_bar_top     <= '0;
      clk_top       <= '0;
      Dis_top       <= '0;
      Dis_Phase_top <= 1'b0;
      out_valid     <= 1'b0;
      s_out         <= '0;
      err_mask      <= '0;
      err           <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      in_ready      <= in_ready_d;
      x_top         <= x_top_d;
      x_bar_top     <= x_bar_top_d;
      k_top         <= k_top_d;
      k_bar_top     <= k_bar_top_d;
      clk_top       <= clk_top_d;
      Dis_top       <= dis_top_d;
      Dis_Phase_top <= dis_phase_d;
      out_valid     <= out_valid_d;
      s_out         <= s_out_d;
      err_mask      <= err_mask_d;
      err           <= err_d;
    end
  end

endmodule

// File: tb/tb_eespfal_lane_driver.sv
// Directed bench for eespfal_lane_driver with a behavioural dual-rail lane model.
module tb_eespfal_lane_driver;

  logic        clk, rst_n;
  logic        in_valid, in_ready;
  logic [63:0] x_in, k_in;
  logic [63:0] x_top, x_bar_top, k_top, k_bar_top;
  logic [3:0]  clk_top, Dis_top;
  logic        Dis_Phase_top;
  logic [63:0] s_top, s_bar_top;
  logic        out_valid, out_ready;
  logic [63:0] s_out, err_mask;
  logic        err;

  int n_vec = 0;
  int n_err = 0;
  int lat;
  logic saw_valid;

  // Lane model: evaluates only with all four phases high, else both rails null
  logic [63:0] force_hi, force_lo;
  logic [63:0] s_true;
  assign s_true    = x_top ^ k_top;
  assign s_top     = (clk_top == 4'hF) ? ((s_true | force_hi) & ~force_lo) : 64'h0;
  assign s_bar_top = (clk_top == 4'hF) ? ((~s_true | force_hi) & ~force_lo) : 64'h0;

  eespfal_lane_driver dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .x_in(x_in), .k_in(k_in),
    .x_top(x_top), .x_bar_top(x_bar_top), .k_top(k_top), .k_bar_top(k_bar_top),
    .clk_top(clk_top), .Dis_top(Dis_top), .Dis_Phase_top(Dis_Phase_top),
    .s_top(s_top), .s_bar_top(s_bar_top),
    .out_valid(out_valid), .out_ready(out_ready),
    .s_out(s_out), .err_mask(err_mask), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected power-clock pattern for cycle c after the accepting edge
  function automatic logic [3:0] exp_clk(input int c);
    if (c >= 1 && c <= 16) begin
      case ((c - 1) / 4)
        0: return 4'b0001;
        1: return 4'b0011;
        2: return 4'b0111;
        default: return 4'b1111;
      endcase
    end else if (c == 17 || c == 18) begin
      return 4'b1111;
    end else if (c >= 19 && c <= 34) begin
      case ((c - 19) / 4)
        0: return 4'b1110;
        1: return 4'b1100;
        2: return 4'b1000;
        default: return 4'b0000;
      endcase
    end
    return 4'b0000;
  endfunction

  function automatic logic [3:0] exp_dis(input int c);
    return (c >= 35 && c <= 38) ? 4'hF : 4'h0;
  endfunction

  // Called in cycle 0 (just after the accepting edge); tracks the op to out_valid
  task automatic track_op(input logic [63:0] xv, input logic [63:0] kv, output int latency);
    chk("accept_in_ready", 64'(in_ready), 64'h0);
    chk("drive_x_top", x_top, xv);
    chk("drive_k_bar_top", k_bar_top, ~kv);
    latency = -1;
    for (int c = 1; c <= 60; c++) begin
      step();
      chk($sformatf("clk_top_c%0d", c), 64'(clk_top), 64'(exp_clk(c)));
      chk($sformatf("dis_top_c%0d", c), 64'(Dis_top), 64'(exp_dis(c)));
      chk($sformatf("dis_phase_c%0d", c), 64'(Dis_Phase_top), (c >= 35 && c <= 38) ? 64'h1 : 64'h0);
      chk($sformatf("x_top_c%0d", c), x_top, (c <= 34) ? xv : 64'h0);
      chk($sformatf("x_rail_excl_c%0d", c), x_top & x_bar_top, 64'h0);
      chk($sformatf("k_rail_excl_c%0d", c), k_top & k_bar_top, 64'h0);
      if (out_valid) begin
        latency = c;
        break;
      end
    end
    chk("latency", 64'(latency), 64'd39);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    x_in = '0; k_in = '0; force_hi = '0; force_lo = '0;

    // 1: reset and idle
    #3;
    chk("rst_clk_top", 64'(clk_top), 64'h0);
    chk("rst_out_valid", 64'(out_valid), 64'h0);
    chk("rst_s_out", s_out, 64'h0);
    #19 rst_n = 1'b1;
    step();
    chk("in_ready_after_release", 64'(in_ready), 64'h1);
    for (int i = 0; i < 19; i++) step();
    chk("idle_in_ready", 64'(in_ready), 64'h1);
    chk("idle_clk_top", 64'(clk_top), 64'h0);
    chk("idle_dis_top", 64'(Dis_top), 64'h0);
    chk("idle_x_rails", x_top | x_bar_top, 64'h0);
    chk("idle_k_rails", k_top | k_bar_top, 64'h0);
    chk("idle_out_valid", 64'(out_valid), 64'h0);
    chk("idle_err", 64'(err), 64'h0);

    // 2/3: nominal op with phase timing
    x_in = 64'h0123_4567_89AB_CDEF; k_in = 64'hFFFF_0000_FFFF_0000; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    track_op(64'h0123_4567_89AB_CDEF, 64'hFFFF_0000_FFFF_0000, lat);
    chk("op1_s_out", s_out, 64'hFEDC_4567_7654_CDEF);
    chk("op1_err", 64'(err), 64'h0);
    chk("op1_err_mask", err_mask, 64'h0);
    step();
    chk("op1_valid_drop", 64'(out_valid), 64'h0);
    chk("op1_idle_ready", 64'(in_ready), 64'h1);
    chk("op1_s_out_held", s_out, 64'hFEDC_4567_7654_CDEF);

    // 4: rail-equal faults on bits 5 and 60, out_ready held low
    force_hi = 64'h0000_0000_0000_0020; force_lo = 64'h1000_0000_0000_0000;
    out_ready = 1'b0;
    x_in = 64'h0000_0000_FFFF_0000; k_in = 64'h0; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    track_op(64'h0000_0000_FFFF_0000, 64'h0, lat);
    chk("op2_err", 64'(err), 64'h1);
    chk("op2_err_mask", err_mask, 64'h1000_0000_0000_0020);
    chk("op2_s_out", s_out, 64'h0000_0000_FFFF_0020);
    force_hi = '0; force_lo = '0;

    // 5: back-pressure in DONE with a pending request
    x_in = 64'hDEAD_BEEF_0000_FFFF; k_in = 64'h0F0F_0F0F_0F0F_0F0F; in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("bp_out_valid", 64'(out_valid), 64'h1);
      chk("bp_s_out", s_out, 64'h0000_0000_FFFF_0020);
      chk("bp_in_ready", 64'(in_ready), 64'h0);
      chk("bp_clk_top", 64'(clk_top), 64'h0);
    end
    out_ready = 1'b1;
    step();
    chk("bp_release_valid", 64'(out_valid), 64'h0);
    chk("bp_release_ready", 64'(in_ready), 64'h1);
    step();
    in_valid = 1'b0;
    track_op(64'hDEAD_BEEF_0000_FFFF, 64'h0F0F_0F0F_0F0F_0F0F, lat);
    chk("op3_s_out", s_out, 64'hD1A2_B1E0_0F0F_F0F0);
    chk("op3_err", 64'(err), 64'h0);
    step();

    // 6: asynchronous reset at EVAL offset 6
    x_in = 64'h1111_2222_3333_4444; k_in = 64'h5555_6666_7777_8888; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 7; i++) step();
    chk("pre_rst_clk_top", 64'(clk_top), 64'h3);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_clk_top", 64'(clk_top), 64'h0);
    chk("async_rst_x_top", x_top, 64'h0);
    chk("async_rst_k_bar_top", k_bar_top, 64'h0);
    chk("async_rst_dis_top", 64'(Dis_top), 64'h0);
    chk("async_rst_s_out", s_out, 64'h0);
    step();
    step();
    #3 rst_n = 1'b1;
    saw_valid = 1'b0;
    for (int i = 0; i < 45; i++) begin
      step();
      if (out_valid) saw_valid = 1'b1;
    end
    chk("no_valid_after_rst", 64'(saw_valid), 64'h0);
    chk("post_rst_in_ready", 64'(in_ready), 64'h1);
    x_in = 64'hAAAA_5555_0000_FFFF; k_in = 64'h0; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    track_op(64'hAAAA_5555_0000_FFFF, 64'h0, lat);
    chk("op4_s_out", s_out, 64'hAAAA_5555_0000_FFFF);
    chk("op4_err_mask", err_mask, 64'h0);
    step();
    chk("op4_valid_drop", 64'(out_valid), 64'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
